// File: rtl/pipelined_shifter_if.sv
// pipelined_shifter_if: handshake bundle for the pipelined barrel shifter.
//   in_vld/in_rdy/src/amt/op : operand side (master drives vld + payload)
//   out_vld/out_rdy/res      : result side (master drives out_rdy)
//   sticky                   : only with SHIFTER_STICKY_EN; OR of bits shifted
//                              out of the LSB for right shifts, aligned with res
interface pipelined_shifter_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
);
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] src;
  logic [AMT_W-1:0] amt;
  logic [1:0]       op;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] res;
`ifdef SHIFTER_STICKY_EN
  logic             sticky;
`endif

  modport master (
    output in_vld, src, amt, op, out_rdy,
    input  in_rdy, out_vld, res
`ifdef SHIFTER_STICKY_EN
    , input sticky
`endif
  );

  modport slave (
    input  in_vld, src, amt, op, out_rdy,
    output in_rdy, out_vld, res
`ifdef SHIFTER_STICKY_EN
    , output sticky
`endif
  );
endinterface

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: elastic, fully pipelined barrel shifter.
//   WIDTH-bit operand, AMT_W = log2(WIDTH) registered stages; stage k applies
//   a 2^k shift when amt[k] is set. op: 00 lsr, 01 asr, 10 lsl, 11 ror.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipelined_shifter_if.slave (in_vld/in_rdy/src/amt/op,
//                out_vld/out_rdy/res, plus sticky when enabled)
// Optional feature: define SHIFTER_STICKY_EN to add the sticky output and the
// per-stage sticky accumulators.

// One pipeline stage: a valid bit plus data/amt/op (and sticky) registers.
module shifter_stage #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] d_in,
  input  logic [AMT_W-1:0] amt_in,
  input  logic [1:0]       op_in,
  output logic             vld,
  output logic [WIDTH-1:0] d,
  output logic [AMT_W-1:0] amt,
  output logic [1:0]       op
`ifdef SHIFTER_STICKY_EN
  , input  logic           stk_in
  , output logic           stk
`endif
);
  localparam int S = 1 << K;

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = d_in;
    if (amt_in[K]) begin
      case (op_in)
        2'b00:   shifted = {{S{1'b0}}, d_in[WIDTH-1:S]};
        2'b01:   shifted = {{S{d_in[WIDTH-1]}}, d_in[WIDTH-1:S]};
        2'b10:   shifted = {d_in[WIDTH-1-S:0], {S{1'b0}}};
        default: shifted = {d_in[S-1:0], d_in[WIDTH-1:S]};
      endcase
    end
  end

  // Loading when empty or when downstream drains collapses bubbles; payload
  // is only captured for a real item so res holds its last value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      d   <= '0;
      amt <= '0;
      op  <= '0;
    end else if (ld) begin
      vld <= up_vld;
      if (up_vld) begin
        d   <= shifted;
        amt <= amt_in;
        op  <= op_in;
      end
    end
  end

`ifdef SHIFTER_STICKY_EN
  // Bits falling off the LSB on a right shift are the low S bits of d_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stk <= 1'b0;
    else if (ld && up_vld)
      stk <= stk_in | (amt_in[K] & ~op_in[1] & (|d_in[S-1:0]));
  end
`endif
endmodule

module pipelined_shifter #(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_shifter_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_shifter: WIDTH must be a power of 2 and >= 4");
  end

  // Index 0 is the input side; index k+1 is the output of stage k.
  logic [AMT_W:0]            vld_pipe;
  logic [AMT_W-1:0]          rdy_pipe;
  logic [AMT_W:0][WIDTH-1:0] dat_pipe;
  logic [AMT_W:0][AMT_W-1:0] amt_pipe;
  logic [AMT_W:0][1:0]       op_pipe;
`ifdef SHIFTER_STICKY_EN
  logic [AMT_W:0]            stk_pipe;
  assign stk_pipe[0] = 1'b0;
`endif

  assign vld_pipe[0] = bus.in_vld;
  assign dat_pipe[0] = bus.src;
  assign amt_pipe[0] = bus.amt;
  assign op_pipe[0]  = bus.op;

  // Ready ripples back from out_rdy: a stage accepts if it is empty or the
  // stage after it is accepting this cycle.
  always_comb begin
    logic r;
    r = bus.out_rdy;
    rdy_pipe = '0;
    for (int k = AMT_W - 1; k >= 0; k--) begin
      r = !vld_pipe[k+1] || r;
      rdy_pipe[k] = r;
    end
  end

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    shifter_stage #(.WIDTH(WIDTH), .AMT_W(AMT_W), .K(k)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .ld     (rdy_pipe[k]),
      .up_vld (vld_pipe[k]),
      .d_in   (dat_pipe[k]),
      .amt_in (amt_pipe[k]),
      .op_in  (op_pipe[k]),
      .vld    (vld_pipe[k+1]),
      .d      (dat_pipe[k+1]),
      .amt    (amt_pipe[k+1]),
      .op     (op_pipe[k+1])
`ifdef SHIFTER_STICKY_EN
      , .stk_in (stk_pipe[k])
      , .stk    (stk_pipe[k+1])
`endif
    );
  end

  // The last stage's control fields have no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt_pipe[AMT_W], op_pipe[AMT_W]};

  assign bus.in_rdy  = rdy_pipe[0];
  assign bus.out_vld = vld_pipe[AMT_W];
  assign bus.res     = dat_pipe[AMT_W];
`ifdef SHIFTER_STICKY_EN
  assign bus.sticky  = stk_pipe[AMT_W];
`endif
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: self-checking bench for pipelined_shifter (WIDTH=16).
// Inputs change #1 after posedge; handshakes are sampled on the negedge.
module tb_pipelined_shifter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_shifter_if #(.WIDTH(W)) bus ();
  pipelined_shifter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] src;
    logic [3:0]  amt;
    logic [1:0]  op;
  } item_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  item_t       acc_q[$];
  int          acc_cyc_q[$];
  logic [15:0] res_q[$];
  logic        stk_q[$];
  int          out_cyc_q[$];

  function automatic item_t mk(logic [15:0] s, logic [3:0] a, logic [1:0] o);
    item_t it;
    it.src = s; it.amt = a; it.op = o;
    return it;
  endfunction

  function automatic item_t rnd_item();
    return mk(16'($urandom), 4'($urandom), 2'($urandom));
  endfunction

  // Reference: whole-word shift by the full amount.
  function automatic logic [15:0] ref_res(item_t it);
    logic [31:0] dbl;
    case (it.op)
      2'b00:   return it.src >> it.amt;
      2'b01:   return 16'($signed(it.src) >>> it.amt);
      2'b10:   return it.src << it.amt;
      default: begin
        dbl = {it.src, it.src} >> it.amt;
        return dbl[15:0];
      end
    endcase
  endfunction

  function automatic logic ref_stk(item_t it);
    logic [15:0] mask;
    mask = (16'd1 << it.amt) - 16'd1;
    return !it.op[1] && ((it.src & mask) != 16'd0);
  endfunction

  task automatic clear_q();
    acc_q.delete(); acc_cyc_q.delete();
    res_q.delete(); stk_q.delete(); out_cyc_q.delete();
  endtask

  // Monitor one clock: record transfers on both interfaces.
  task automatic cycle();
    @(negedge clk);
    if (bus.in_vld && bus.in_rdy) begin
      acc_q.push_back(mk(bus.src, bus.amt, bus.op));
      acc_cyc_q.push_back(cyc);
    end
    if (bus.out_vld && bus.out_rdy) begin
      res_q.push_back(bus.res);
`ifdef SHIFTER_STICKY_EN
      stk_q.push_back(bus.sticky);
`else
      stk_q.push_back(1'b0);
`endif
      out_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present list in order (valid held until accepted) and drain it.
  task automatic drive_stream(input item_t list[$], input int vld_pct,
                              input int rdy_pct, input int max_cyc,
                              output bit timeout);
    int idx = 0;
    int n = list.size();
    int na;
    timeout = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (idx < n) begin
        if (!bus.in_vld) bus.in_vld = ($urandom_range(99) < vld_pct);
        bus.src = list[idx].src;
        bus.amt = list[idx].amt;
        bus.op  = list[idx].op;
      end else begin
        bus.in_vld = 1'b0;
      end
      bus.out_rdy = ($urandom_range(99) < rdy_pct);
      na = acc_q.size();
      cycle();
      if (acc_q.size() != na) begin
        idx++;
        bus.in_vld = 1'b0;
      end
      if (idx == n && res_q.size() == n) begin
        timeout = 1'b0;
        break;
      end
    end
    bus.in_vld = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_vld = 1'b0; bus.out_rdy = 1'b0;
    bus.src = '0; bus.amt = '0; bus.op = '0;
    rst_n = 1'b0;
    #2;
    tests++;
    if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL reset_out_vld got %b exp 0", bus.out_vld); end
    tests++;
    if (bus.res !== 16'h0) begin fails++; $display("FAIL reset_res got %h exp 0000", bus.res); end
    tests++;
    if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy got %b exp 1", bus.in_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ops_latency();
    item_t list[$];
    logic [15:0] exp_r [3] = '{16'h4000, 16'hC000, 16'h0002};
    bit to;
    clear_q();
    for (int i = 0; i < 3; i++) list.push_back(mk(16'h8001, 4'd1, 2'(i)));
    drive_stream(list, 100, 100, 40, to);
    tests++;
    if (to || res_q.size() != 3) begin
      fails++; $display("FAIL ops_count got %0d exp 3 (timeout=%0b)", res_q.size(), to);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (res_q[i] !== exp_r[i]) begin fails++; $display("FAIL ops_res[%0d] got %h exp %h", i, res_q[i], exp_r[i]); end
      end
      tests++;
      if (out_cyc_q[0] - acc_cyc_q[0] != 4) begin
        fails++; $display("FAIL ops_latency got %0d exp 4", out_cyc_q[0] - acc_cyc_q[0]);
      end
      tests++;
      if (out_cyc_q[2] - out_cyc_q[0] != 2) begin
        fails++; $display("FAIL ops_consecutive got %0d exp 2", out_cyc_q[2] - out_cyc_q[0]);
      end
    end
  endtask

  task automatic test_rotate_extremes();
    item_t list[$];
    logic [15:0] exp_r [7] = '{16'h4123, 16'hFFFF, 16'h0001,
                               16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
    bit to;
    clear_q();
    list.push_back(mk(16'h1234, 4'd4, 2'b11));
    list.push_back(mk(16'h8000, 4'd15, 2'b01));
    list.push_back(mk(16'h8000, 4'd15, 2'b00));
    for (int i = 0; i < 4; i++) list.push_back(mk(16'hA5A5, 4'd0, 2'(i)));
    drive_stream(list, 70, 60, 200, to);
    tests++;
    if (to || res_q.size() != 7) begin
      fails++; $display("FAIL extremes_count got %0d exp 7 (timeout=%0b)", res_q.size(), to);
    end else begin
      for (int i = 0; i < 7; i++) begin
        tests++;
        if (res_q[i] !== exp_r[i]) begin fails++; $display("FAIL extremes_res[%0d] got %h exp %h", i, res_q[i], exp_r[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int idx = 1;
    int na;
    clear_q();
    bus.out_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.in_vld = (idx <= 6);
      bus.src = 16'(idx); bus.amt = '0; bus.op = 2'($urandom);
      na = acc_q.size();
      cycle();
      if (acc_q.size() != na) idx++;
    end
    tests++;
    if (acc_q.size() != 4) begin fails++; $display("FAIL bp_accepted got %0d exp 4", acc_q.size()); end
    tests++;
    if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL bp_in_rdy got %b exp 0", bus.in_rdy); end
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (bus.out_vld !== 1'b1 || bus.res !== 16'h0001) begin
        fails++; $display("FAIL bp_hold vld=%b res=%h exp 1/0001", bus.out_vld, bus.res);
      end
      cycle();
    end
    bus.out_rdy = 1'b1;
    for (int c = 0; c < 30 && res_q.size() < 6; c++) begin
      bus.in_vld = (idx <= 6);
      bus.src = 16'(idx); bus.amt = '0; bus.op = 2'($urandom);
      na = acc_q.size();
      cycle();
      if (acc_q.size() != na) idx++;
    end
    bus.in_vld = 1'b0;
    tests++;
    if (res_q.size() != 6) begin
      fails++; $display("FAIL bp_count got %0d exp 6", res_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (res_q[i] !== 16'(i + 1)) begin fails++; $display("FAIL bp_order[%0d] got %h exp %h", i, res_q[i], 16'(i + 1)); end
      end
    end
  endtask

  task automatic test_bubble();
    item_t items[5];
    int na;
    clear_q();
    for (int i = 0; i < 5; i++) items[i] = rnd_item();
    bus.out_rdy = 1'b0;
    bus.in_vld = 1'b1;
    bus.src = items[0].src; bus.amt = items[0].amt; bus.op = items[0].op;
    cycle();
    bus.in_vld = 1'b0;
    repeat (3) cycle();
    for (int i = 1; i < 4; i++) begin
      bus.in_vld = 1'b1;
      bus.src = items[i].src; bus.amt = items[i].amt; bus.op = items[i].op;
      tests++;
      if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL bubble_in_rdy[%0d] got %b exp 1", i, bus.in_rdy); end
      na = acc_q.size();
      cycle();
    end
    bus.src = items[4].src; bus.amt = items[4].amt; bus.op = items[4].op;
    tests++;
    if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL bubble_full got %b exp 0", bus.in_rdy); end
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b1;
    for (int c = 0; c < 20 && res_q.size() < 4; c++) cycle();
    tests++;
    if (res_q.size() != 4) begin
      fails++; $display("FAIL bubble_count got %0d exp 4", res_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (res_q[i] !== ref_res(items[i])) begin fails++; $display("FAIL bubble_res[%0d] got %h exp %h", i, res_q[i], ref_res(items[i])); end
      end
    end
  endtask

  task automatic test_back_to_back();
    item_t list[$];
    bit to;
    clear_q();
    for (int i = 0; i < 20; i++) list.push_back(rnd_item());
    drive_stream(list, 100, 100, 60, to);
    tests++;
    if (to || res_q.size() != 20) begin
      fails++; $display("FAIL b2b_count got %0d exp 20 (timeout=%0b)", res_q.size(), to);
    end else begin
      for (int i = 0; i < 20; i++) begin
        tests++;
        if (res_q[i] !== ref_res(list[i])) begin fails++; $display("FAIL b2b_res[%0d] got %h exp %h", i, res_q[i], ref_res(list[i])); end
      end
      tests++;
      if (out_cyc_q[19] - out_cyc_q[0] != 19 || acc_cyc_q[19] - acc_cyc_q[0] != 19) begin
        fails++; $display("FAIL b2b_throughput out_span=%0d in_span=%0d exp 19", out_cyc_q[19] - out_cyc_q[0], acc_cyc_q[19] - acc_cyc_q[0]);
      end
    end
  endtask

  task automatic test_random();
    item_t list[$];
    bit to;
    clear_q();
    for (int i = 0; i < 150; i++) list.push_back(rnd_item());
    drive_stream(list, 60, 50, 3000, to);
    tests++;
    if (to || res_q.size() != 150) begin
      fails++; $display("FAIL rand_count got %0d exp 150 (timeout=%0b)", res_q.size(), to);
    end else begin
      for (int i = 0; i < 150; i++) begin
        tests++;
        if (res_q[i] !== ref_res(list[i])) begin fails++; $display("FAIL rand_res[%0d] got %h exp %h", i, res_q[i], ref_res(list[i])); end
`ifdef SHIFTER_STICKY_EN
        tests++;
        if (stk_q[i] !== ref_stk(list[i])) begin fails++; $display("FAIL rand_sticky[%0d] got %b exp %b", i, stk_q[i], ref_stk(list[i])); end
`endif
      end
    end
  endtask

  task automatic test_reset_midstream();
    clear_q();
    bus.out_rdy = 1'b0;
    for (int c = 0; c < 6 && acc_q.size() < 3; c++) begin
      bus.in_vld = 1'b1;
      bus.src = 16'($urandom) | 16'h1; bus.amt = '0; bus.op = 2'($urandom);
      cycle();
    end
    bus.in_vld = 1'b0;
    repeat (2) cycle();
    tests++;
    if (acc_q.size() != 3 || bus.out_vld !== 1'b1) begin
      fails++; $display("FAIL rstmid_setup accepted=%0d out_vld=%b exp 3/1", acc_q.size(), bus.out_vld);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_vld !== 1'b0 || bus.res !== 16'h0 || bus.in_rdy !== 1'b1) begin
      fails++; $display("FAIL rstmid_clear vld=%b res=%h rdy=%b exp 0/0000/1", bus.out_vld, bus.res, bus.in_rdy);
    end
    #1;
    rst_n = 1'b1;
    bus.out_rdy = 1'b1;
    repeat (10) cycle();
    tests++;
    if (res_q.size() != 0) begin fails++; $display("FAIL rstmid_stale got %0d outputs exp 0", res_q.size()); end
  endtask

`ifdef SHIFTER_STICKY_EN
  task automatic test_sticky();
    item_t list[$];
    logic [15:0] exp_r [4] = '{16'h0001, 16'h0001, 16'h0FF0, 16'hF00F};
    logic        exp_s [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    bit to;
    clear_q();
    list.push_back(mk(16'h0003, 4'd1, 2'b00));
    list.push_back(mk(16'h0010, 4'd4, 2'b01));
    list.push_back(mk(16'h00FF, 4'd4, 2'b10));
    list.push_back(mk(16'h00FF, 4'd4, 2'b11));
    drive_stream(list, 100, 100, 40, to);
    tests++;
    if (to || res_q.size() != 4) begin
      fails++; $display("FAIL sticky_count got %0d exp 4 (timeout=%0b)", res_q.size(), to);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (res_q[i] !== exp_r[i] || stk_q[i] !== exp_s[i]) begin
          fails++; $display("FAIL sticky[%0d] got %h/%b exp %h/%b", i, res_q[i], stk_q[i], exp_r[i], exp_s[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ops_latency();
    test_rotate_extremes();
    test_backpressure();
    test_bubble();
    test_back_to_back();
    test_random();
    test_reset_midstream();
`ifdef SHIFTER_STICKY_EN
    test_sticky();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
